// File: rtl/analyzer_pkg.sv
// Shared definitions for the sample-analysis pipeline.
//   wr_state_e    : sample_framer writer states (FILL, WAIT)
//   DEF_DATA_W    : default sample width
//   DEF_FRAME_LEN : default samples per frame
//   FRAME_CNT_W   : width of the published-frame counter
package analyzer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } wr_state_e;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_FRAME_LEN = 64;
    localparam int FRAME_CNT_W   = 8;

endpackage

// File: rtl/sample_framer_edge_sync.sv
// edge_sync: brings an asynchronous divided clock into the clk domain and
// produces a one-cycle registered strobe per rising edge of that clock.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   async_in : asynchronous square wave (e.g. divided sample clock)
//   strobe   : one-cycle pulse, 3 clk edges after async_in rises
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic strobe
);

    logic       s1_q;
    logic       s2_q;
    logic       s3_q;
    logic       armed_q;
    logic       strobe_q;
    logic [1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            s1_q     <= async_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            fill_q   <= {fill_q[0], 1'b1};
            // The reset zeros in s1/s2 are not real observations of the input;
            // only arm once s2 carries a genuine low, so an input held high
            // through reset release never produces a strobe.
            if (fill_q[1] && !s2_q) begin
                armed_q <= 1'b1;
            end
            strobe_q <= s2_q & ~s3_q & armed_q;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/sample_framer.sv
// sample_framer: groups ADC samples into fixed-length frames in a two-bank
// buffer and publishes each completed frame to a downstream consumer.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sample_clk  : divided sample clock (asynchronous)
//   sample_in   : ADC sample, captured on each sample_clk rising edge
//   rd_addr     : read index into the published frame
//   frame_done  : consumer pulse releasing the published frame
//   frame_valid : a published frame is readable
//   rd_data     : registered read data (1-cycle latency)
//   frame_cnt   : number of frames published (wraps)
//   overrun     : sticky, at least one sample was dropped
module sample_framer
    import analyzer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_clk,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   frame_done,
    output logic                   frame_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    logic                   strobe;
    wr_state_e              state_q;
    logic                   wr_bank_q;
    logic                   rd_bank_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic                   frame_valid_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   overrun_q;
    logic [DATA_W-1:0]      rd_data_q;

    logic [DATA_W-1:0]      mem [2*FRAME_LEN];

    logic                   we;
    logic                   done_ok;
    logic                   publish;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sample_clk),
        .strobe   (strobe)
    );

    always_comb begin
        we      = strobe && (state_q == FILL);
        done_ok = frame_done && frame_valid_q;
        // A full frame publishes immediately if the reader is free (or being
        // freed this very cycle); a held frame publishes on release.
        publish = (we && (wr_addr_q == LAST_ADDR) && (!frame_valid_q || frame_done))
               || ((state_q == WAIT) && done_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            wr_addr_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            if (strobe && (state_q == WAIT)) begin
                overrun_q <= 1'b1;
            end
            if (publish) begin
                rd_bank_q     <= wr_bank_q;
                wr_bank_q     <= ~wr_bank_q;
                wr_addr_q     <= '0;
                frame_valid_q <= 1'b1;
                frame_cnt_q   <= frame_cnt_q + 1'b1;
                state_q       <= FILL;
            end else begin
                if (done_ok) begin
                    frame_valid_q <= 1'b0;
                end
                if (we) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_q <= WAIT;
                    end else begin
                        wr_addr_q <= wr_addr_q + 1'b1;
                    end
                end
            end
        end
    end

    // Buffer storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank_q, wr_addr_q}] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_bank_q, rd_addr}];
        end
    end

    assign frame_valid = frame_valid_q;
    assign rd_data     = rd_data_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;

    logic        clk;
    logic        rst_n;
    logic        sample_clk;
    logic [11:0] sample_in;
    logic [5:0]  rd_addr;
    logic        frame_done;
    logic        frame_valid;
    logic [11:0] rd_data;
    logic [7:0]  frame_cnt;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [11:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];
    rd_vec_t sb[$];

    sample_framer #(
        .DATA_W    (12),
        .FRAME_LEN (64),
        .ADDR_W    (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_clk  (sample_clk),
        .sample_in   (sample_in),
        .rd_addr     (rd_addr),
        .frame_done  (frame_done),
        .frame_valid (frame_valid),
        .rd_data     (rd_data),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int a, input int e);
        rd_vec_t v;
        v.addr = 6'(a);
        v.exp  = 12'(e);
        vecs.push_back(v);
    endfunction

    // Apply the queued read vectors back to back; each expected value goes to
    // the scoreboard when the address is driven and is compared one cycle later.
    task automatic run_reads(input string tag);
        rd_vec_t r;
        for (int i = 0; i <= vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                r = sb.pop_front();
                check($sformatf("%s_rd[%0d]", tag, r.addr), 32'(rd_data), 32'(r.exp));
            end
            if (i < vecs.size()) begin
                rd_addr = vecs[i].addr;
                sb.push_back(vecs[i]);
            end
        end
        vecs.delete();
    endtask

    task automatic send_sample(input int v);
        @(negedge clk);
        sample_in  = 12'(v);
        sample_clk = 1'b1;
        repeat (26) @(negedge clk);
        sample_clk = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    // Final sample of a frame with the reader free: frame_valid must still be
    // low after 3 edges and high after the 4th.
    task automatic send_last_checked(input int v, input string tag);
        @(negedge clk);
        sample_in  = 12'(v);
        sample_clk = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_valid_early"}, 32'(frame_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid_pub"}, 32'(frame_valid), 32'd1);
        repeat (22) @(negedge clk);
        sample_clk = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    // Final sample of a frame with frame_done landing on the write edge.
    task automatic send_last_with_done(input int v, input int cnt_before);
        @(negedge clk);
        sample_in  = 12'(v);
        sample_clk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("coinc_valid_pre%0d", i), 32'(frame_valid), 32'd1);
        end
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        check("coinc_valid_at", 32'(frame_valid), 32'd1);
        check("coinc_cnt_at", 32'(frame_cnt), 32'(cnt_before + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("coinc_valid_post%0d", i), 32'(frame_valid), 32'd1);
        end
        repeat (19) @(negedge clk);
        sample_clk = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    initial begin
        // Reset with sample_clk held high
        rst_n      = 1'b0;
        sample_clk = 1'b1;
        sample_in  = 12'h5A5;
        frame_done = 1'b0;
        rd_addr    = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_valid", 32'(frame_valid), 32'd0);
        check("post_rst_cnt", 32'(frame_cnt), 32'd0);
        sample_clk = 1'b0;
        repeat (26) @(negedge clk);

        // Frame 1: ramp 0..63; a spurious write from the held-high clock would
        // publish one sample early and shift the contents.
        for (int k = 0; k < 63; k++) send_sample(k);
        send_last_checked(63, "f1");
        check("f1_cnt", 32'(frame_cnt), 32'd1);
        for (int k = 0; k < 64; k++) add_vec(k, k);
        add_vec(63, 63);
        add_vec(0, 0);
        add_vec(17, 17);
        run_reads("f1");

        pulse_done();
        check("f1_released", 32'(frame_valid), 32'd0);

        // Frame 2: ramp 100..163
        for (int k = 100; k < 163; k++) send_sample(k);
        send_last_checked(163, "f2");
        check("f2_cnt", 32'(frame_cnt), 32'd2);
        check("f2_overrun", 32'(overrun), 32'd0);
        add_vec(0, 100);
        add_vec(63, 163);
        add_vec(42, 142);
        run_reads("f2");

        // Frame 3 with reader busy, then 5 extra samples
        for (int k = 200; k < 264; k++) send_sample(k);
        check("f3_held_cnt", 32'(frame_cnt), 32'd2);
        check("f3_held_valid", 32'(frame_valid), 32'd1);
        check("f3_held_overrun", 32'(overrun), 32'd0);
        add_vec(0, 100);
        add_vec(63, 163);
        run_reads("f3_old");
        for (int k = 500; k < 505; k++) send_sample(k);
        check("f3_overrun", 32'(overrun), 32'd1);
        check("f3_wait_cnt", 32'(frame_cnt), 32'd2);
        pulse_done();
        check("f3_pub_valid", 32'(frame_valid), 32'd1);
        check("f3_pub_cnt", 32'(frame_cnt), 32'd3);
        add_vec(0, 200);
        add_vec(4, 204);
        add_vec(5, 205);
        add_vec(63, 263);
        run_reads("f3");

        // Frame 4: frame_done coincides with the final write
        for (int k = 300; k < 363; k++) send_sample(k);
        send_last_with_done(363, 3);
        check("f4_cnt", 32'(frame_cnt), 32'd4);
        check("f4_overrun_sticky", 32'(overrun), 32'd1);
        add_vec(0, 300);
        add_vec(63, 363);
        add_vec(31, 331);
        run_reads("f4");

        // Reset mid-frame (wr_addr=30) with a frame published
        for (int k = 400; k < 430; k++) send_sample(k);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(frame_valid), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 600; k < 663; k++) send_sample(k);
        send_last_checked(663, "f5");
        check("f5_cnt", 32'(frame_cnt), 32'd1);
        add_vec(0, 600);
        add_vec(29, 629);
        add_vec(30, 630);
        add_vec(63, 663);
        run_reads("f5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
